// File: rtl/dm_pkg.sv
// Shared constants, FSM encoding and the address-window check for the
// data-memory arbiter.
package dm_pkg;

    localparam logic [31:0] DM_BASE = 32'h6600_0000;
    localparam logic [31:0] DM_LAST = 32'h6600_00FC;

    localparam int P_CORE = 0;
    localparam int P_DBG  = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // A word access is legal only when it lies inside the DM window and is word aligned.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] last);
        return (addr >= base) && (addr <= last) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; when a lock is active only the owner can win.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr,
    input  logic       lock_en,
    input  logic       lock_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (lock_en) begin
            grant[lock_owner] = valid[lock_owner];
        end else if (valid == 2'b11) begin
            grant[rr] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory: round-robin grant,
// locked bursts with an idle watchdog, and a registered one-cycle response.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = DM_BASE,
    parameter logic [31:0] ADDR_LAST = DM_LAST,
    parameter int          MAX_IDLE  = 8,
    parameter int          CNT_W     = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_wd_i,
    input  logic        req0_we_i,
    input  logic        req0_lock_i,
    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_rdata_o,
    output logic        rsp0_err_o,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_wd_i,
    input  logic        req1_we_i,
    input  logic        req1_lock_i,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_rdata_o,
    output logic        rsp1_err_o,

    output logic        lock_to_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rd_i
);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_to_q, lock_to_d;

    logic [1:0]       rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    logic [1:0]       valid;
    logic [1:0]       grant;
    logic             accept;
    logic             win;
    logic [31:0]      win_addr;
    logic [31:0]      win_wd;
    logic             win_we;
    logic             win_lock;
    logic             win_legal;

    assign valid = {req1_valid_i, req0_valid_i};

    rr_arb2 u_pick (
        .valid      (valid),
        .rr         (rr_q),
        .lock_en    (state_q == ST_OWNED),
        .lock_owner (owner_q),
        .grant      (grant)
    );

    assign req0_ready_o = grant[P_CORE];
    assign req1_ready_o = grant[P_DBG];
    assign accept       = |grant;
    assign win          = grant[P_DBG];

    assign win_addr  = win ? req1_addr_i : req0_addr_i;
    assign win_wd    = win ? req1_wd_i   : req0_wd_i;
    assign win_we    = win ? req1_we_i   : req0_we_i;
    assign win_lock  = win ? req1_lock_i : req0_lock_i;
    assign win_legal = addr_legal(win_addr, ADDR_BASE, ADDR_LAST);

    // Memory bus is forced to zero whenever nothing is accepted.
    assign mem_addr_o = accept ? win_addr : 32'h0;
    assign mem_wd_o   = accept ? win_wd   : 32'h0;
    assign mem_we_o   = accept && win_we && win_legal;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        lock_to_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rr_d = ~win;
                    if (win_lock) begin
                        state_d = ST_OWNED;
                        owner_d = win;
                        cnt_d   = '0;
                    end
                end
            end
            ST_OWNED: begin
                // Only the owner can be granted here, so accept means owner valid.
                if (accept) begin
                    cnt_d = '0;
                    if (!win_lock) begin
                        state_d = ST_IDLE;
                        rr_d    = ~owner_q;
                    end
                end else if (cnt_q == CNT_W'(MAX_IDLE - 1)) begin
                    state_d   = ST_IDLE;
                    rr_d      = ~owner_q;
                    cnt_d     = '0;
                    lock_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            lock_to_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            lock_to_q <= lock_to_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            rsp_rdata_q <= (accept && win_legal && !win_we) ? mem_rd_i : 32'h0;
            rsp_err_q   <= accept && !win_legal;
        end
    end

    assign lock_to_o    = lock_to_q;
    assign rsp0_valid_o = rsp_valid_q[P_CORE];
    assign rsp0_rdata_o = rsp_valid_q[P_CORE] ? rsp_rdata_q : 32'h0;
    assign rsp0_err_o   = rsp_valid_q[P_CORE] && rsp_err_q;
    assign rsp1_valid_o = rsp_valid_q[P_DBG];
    assign rsp1_rdata_o = rsp_valid_q[P_DBG] ? rsp_rdata_q : 32'h0;
    assign rsp1_err_o   = rsp_valid_q[P_DBG] && rsp_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 64-word DM model behind the memory port.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        r0_valid, r0_ready, r0_we, r0_lock;
    logic [31:0] r0_addr, r0_wd;
    logic        s0_valid, s0_err;
    logic [31:0] s0_rdata;
    logic        r1_valid, r1_ready, r1_we, r1_lock;
    logic [31:0] r1_addr, r1_wd;
    logic        s1_valid, s1_err;
    logic [31:0] s1_rdata;
    logic        lock_to;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] dm [0:63];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req0_valid_i (r0_valid),
        .req0_ready_o (r0_ready),
        .req0_addr_i  (r0_addr),
        .req0_wd_i    (r0_wd),
        .req0_we_i    (r0_we),
        .req0_lock_i  (r0_lock),
        .rsp0_valid_o (s0_valid),
        .rsp0_rdata_o (s0_rdata),
        .rsp0_err_o   (s0_err),
        .req1_valid_i (r1_valid),
        .req1_ready_o (r1_ready),
        .req1_addr_i  (r1_addr),
        .req1_wd_i    (r1_wd),
        .req1_we_i    (r1_we),
        .req1_lock_i  (r1_lock),
        .rsp1_valid_o (s1_valid),
        .rsp1_rdata_o (s1_rdata),
        .rsp1_err_o   (s1_err),
        .lock_to_o    (lock_to),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_we_o     (mem_we),
        .mem_rd_i     (mem_rd)
    );

    // DM model: combinational read, write on the rising edge.
    assign mem_rd = dm[mem_addr[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) dm[i] = 32'h1000_0000 + 32'(i);
        dm[2] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (mem_we) dm[mem_addr[7:2]] = mem_wd;
        end
    end

    task automatic clear_inputs();
        r0_valid = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wd = 0;
        r1_valid = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got %b want 0", s0_valid); end
        checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got %b want 0", s1_valid); end
        checks++; if (lock_to !== 1'b0) begin errors++; $display("FAIL reset_lock_to got %b want 0", lock_to); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        $display("reset: rsp0=%b rsp1=%b lock_to=%b", s0_valid, s1_valid, lock_to);
        #1 rstn = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        r0_valid = 1; r0_addr = 32'h6600_0008;
        @(negedge clk);
        checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b want 1", r0_ready); end
        checks++; if (mem_addr !== 32'h6600_0008) begin errors++; $display("FAIL single_mem_addr got %h want 66000008", mem_addr); end
        tick();
        clear_inputs();
        checks++; if (s0_valid !== 1'b1) begin errors++; $display("FAIL single_rsp0_valid got %b want 1", s0_valid); end
        checks++; if (s0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %h want deadbeef", s0_rdata); end
        checks++; if (s0_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", s0_err); end
        checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_valid got %b want 0", s1_valid); end
        $display("single read: addr=66000008 rdata=%h", s0_rdata);
        tick();
        checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp0_pulse got %b want 0", s0_valid); end
    endtask

    task automatic test_contention();
        logic p1;
        do_reset();
        r0_valid = 1; r0_addr = 32'h6600_0000;
        r1_valid = 1; r1_addr = 32'h6600_0004;
        for (int k = 0; k < 4; k++) begin
            p1 = (k % 2) == 1;
            @(negedge clk);
            checks++; if (r0_ready !== !p1) begin errors++; $display("FAIL contend_ready0 beat %0d got %b want %b", k, r0_ready, !p1); end
            checks++; if (r1_ready !== p1) begin errors++; $display("FAIL contend_ready1 beat %0d got %b want %b", k, r1_ready, p1); end
            tick();
            checks++; if (s0_valid !== !p1 || s1_valid !== p1) begin errors++; $display("FAIL contend_rsp beat %0d got %b%b want %b%b", k, s1_valid, s0_valid, p1, !p1); end
            if (p1) begin
                checks++; if (s1_rdata !== 32'h1000_0001) begin errors++; $display("FAIL contend_rdata1 beat %0d got %h want 10000001", k, s1_rdata); end
            end else begin
                checks++; if (s0_rdata !== 32'h1000_0000) begin errors++; $display("FAIL contend_rdata0 beat %0d got %h want 10000000", k, s0_rdata); end
            end
            $display("contention beat %0d: granted P%0d", k, p1);
        end
        clear_inputs();
    endtask

    task automatic test_window();
        logic [31:0] addrs [4] = '{32'h6600_0100, 32'h6600_0006, 32'h6600_00FC, 32'h65FF_FFFC};
        logic        wes   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        errs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] rds   [4] = '{32'h0, 32'h0, 32'h1000_003F, 32'h0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            r1_valid = 1; r1_addr = addrs[k]; r1_we = wes[k]; r1_wd = 32'hCAFE_F00D;
            @(negedge clk);
            checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL window_ready1 %h got %b want 1", addrs[k], r1_ready); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL window_mem_we %h got %b want 0", addrs[k], mem_we); end
            tick();
            clear_inputs();
            checks++; if (s1_valid !== 1'b1) begin errors++; $display("FAIL window_rsp1_valid %h got %b want 1", addrs[k], s1_valid); end
            checks++; if (s1_err !== errs[k]) begin errors++; $display("FAIL window_err %h got %b want %b", addrs[k], s1_err, errs[k]); end
            checks++; if (s1_rdata !== rds[k]) begin errors++; $display("FAIL window_rdata %h got %h want %h", addrs[k], s1_rdata, rds[k]); end
            $display("window: addr=%h err=%b rdata=%h", addrs[k], s1_err, s1_rdata);
        end
        checks++; if (dm[0] !== 32'h1000_0000) begin errors++; $display("FAIL window_dm0 got %h want 10000000", dm[0]); end
        checks++; if (dm[1] !== 32'h1000_0001) begin errors++; $display("FAIL window_dm1 got %h want 10000001", dm[1]); end
    endtask

    task automatic test_locked_burst();
        do_reset();
        // One P0 beat first so round-robin favours P1 at the start of the burst.
        r0_valid = 1; r0_addr = 32'h6600_0000;
        tick();
        r0_addr = 32'h6600_0008;
        for (int k = 0; k < 4; k++) begin
            r1_valid = 1; r1_we = 1; r1_lock = (k < 3);
            r1_addr = 32'h6600_0040 + 32'(4 * k); r1_wd = 32'hA0 + 32'(k);
            @(negedge clk);
            checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL burst_ready0 beat %0d got %b want 0", k, r0_ready); end
            checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL burst_ready1 beat %0d got %b want 1", k, r1_ready); end
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL burst_mem_we beat %0d got %b want 1", k, mem_we); end
            tick();
            checks++; if (s1_valid !== 1'b1 || s1_err !== 1'b0) begin errors++; $display("FAIL burst_rsp1 beat %0d got v=%b e=%b want v=1 e=0", k, s1_valid, s1_err); end
            $display("burst beat %0d: P1 write %h lock=%b", k, r1_addr, r1_lock);
        end
        r1_valid = 0; r1_we = 0; r1_lock = 0;
        @(negedge clk);
        checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL burst_ready0_after got %b want 1", r0_ready); end
        tick();
        clear_inputs();
        checks++; if (s0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL burst_p0_rdata got %h want deadbeef", s0_rdata); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (dm[16 + k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL burst_dm%0d got %h want %h", 16 + k, dm[16 + k], 32'hA0 + 32'(k)); end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        r0_valid = 1; r0_lock = 1; r0_addr = 32'h6600_0000;
        tick();
        r0_valid = 0; r0_lock = 0;
        r1_valid = 1; r1_addr = 32'h6600_0004;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL wd_ready1 idle %0d got %b want 0", i, r1_ready); end
            checks++; if (lock_to !== 1'b0) begin errors++; $display("FAIL wd_early_lock_to idle %0d got %b want 0", i, lock_to); end
            tick();
        end
        checks++; if (lock_to !== 1'b1) begin errors++; $display("FAIL wd_lock_to got %b want 1", lock_to); end
        checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL wd_ready1_after got %b want 1", r1_ready); end
        $display("watchdog: lock_to=%b after 8 idle cycles, ready1=%b", lock_to, r1_ready);
        tick();
        clear_inputs();
        checks++; if (lock_to !== 1'b0) begin errors++; $display("FAIL wd_pulse got %b want 0", lock_to); end
        checks++; if (s1_valid !== 1'b1) begin errors++; $display("FAIL wd_rsp1 got %b want 1", s1_valid); end

        do_reset();
        r0_valid = 1; r0_lock = 1; r0_addr = 32'h6600_0000;
        tick();
        r0_valid = 0;
        r1_valid = 1; r1_addr = 32'h6600_0004;
        repeat (7) tick();
        r0_valid = 1;
        @(negedge clk);
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL wd_owner_wins got %b%b want 01", r1_ready, r0_ready); end
        tick();
        r0_valid = 0;
        checks++; if (lock_to !== 1'b0) begin errors++; $display("FAIL wd_no_timeout got %b want 0", lock_to); end
        @(negedge clk);
        checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL wd_still_owned got %b want 0", r1_ready); end
        tick();
        checks++; if (lock_to !== 1'b0) begin errors++; $display("FAIL wd_no_timeout2 got %b want 0", lock_to); end
        $display("watchdog: owner beat on idle cycle 8, lock_to=%b", lock_to);
        clear_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        r1_valid = 1; r1_we = 1; r1_lock = 1; r1_addr = 32'h6600_0080; r1_wd = 32'h55;
        @(negedge clk);
        checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL midop_ready1 got %b want 1", r1_ready); end
        tick();
        rstn = 1'b0;
        clear_inputs();
        #1;
        checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL midop_rsp1 got %b want 0", s1_valid); end
        checks++; if (lock_to !== 1'b0) begin errors++; $display("FAIL midop_lock_to got %b want 0", lock_to); end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        r0_valid = 1; r0_addr = 32'h6600_0000;
        r1_valid = 1; r1_addr = 32'h6600_0004;
        @(negedge clk);
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL midop_idle_rr got %b%b want 01", r1_ready, r0_ready); end
        $display("reset mid-op: rsp1=%b ready0=%b ready1=%b", s1_valid, r0_ready, r1_ready);
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_window();
        test_locked_burst();
        test_watchdog();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
